// File: rtl/reg_file_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param_pkg
//  Description : Shared defaults and packed-port slicing helper for the
//                parametrised register file.
//                DEF_WIDTH matches the datapath word width. DEF_DEPTH/DEF_AW
//                match the 32-entry, 5-bit-index register space.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_param_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_AW        = 5;
    localparam int DEF_NUM_RD    = 2;
    localparam bit DEF_ZERO_REG0 = 1'b1;

    // LSB position of field 'idx' in a packed multi-port bus of 'fw'-bit fields
    function automatic int slice_lsb(input int idx, input int fw);
        return idx * fw;
    endfunction

endpackage : reg_file_param_pkg
`default_nettype wire

// File: rtl/reg_word_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_word_param
//  Description : One WIDTH-bit storage word with load enable and
//                asynchronous active-high reset.
//  Ports       : CLK   - clock, rising edge
//                RESET - asynchronous active-high reset, clears Q
//                LOAD  - when high at a rising edge, Q takes D
//                D     - data in  [WIDTH-1:0]
//                Q     - data out [WIDTH-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
import reg_file_param_pkg::*;

module reg_word_param #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            word_q <= '0;
        end else if (LOAD) begin
            word_q <= D;
        end
    end

    assign Q = word_q;

endmodule : reg_word_param
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param
//  Description : Parametrised register file. It has one synchronous write
//                port and NUM_RD registered read ports with 1-cycle latency.
//                Same-edge writes bypass to the read ports. Register 0 can
//                be hard-wired to zero. A read-valid strobe is provided.
//  Ports       : CLK      - clock, rising edge
//                RESET    - asynchronous active-high reset
//                WRITE    - write enable
//                ADDR_W   - write address [AW-1:0]
//                DATA_W   - write data [WIDTH-1:0]
//                READ     - read enable, common to all read ports
//                ADDR_R   - packed read addresses, port k at [k*AW +: AW]
//                DATA_R   - packed read data, port k at [k*WIDTH +: WIDTH]
//                RD_VALID - high for one cycle after a sampled READ
//  Revision    : 1.0 - initial release
// ============================================================================
import reg_file_param_pkg::*;

module reg_file_param #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = DEF_AW,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter bit ZERO_REG0 = DEF_ZERO_REG0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    WRITE,
    input  logic [AW-1:0]           ADDR_W,
    input  logic [WIDTH-1:0]        DATA_W,
    input  logic                    READ,
    input  logic [NUM_RD*AW-1:0]    ADDR_R,
    output logic [NUM_RD*WIDTH-1:0] DATA_R,
    output logic                    RD_VALID
);

    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]        wr_sel;
    logic                    wr_accept;
    logic [NUM_RD*WIDTH-1:0] data_r_d;
    logic [NUM_RD*WIDTH-1:0] data_r_q;
    logic                    rd_valid_q;

    // One-hot write decode plus storage words. Only indices below DEPTH
    // exist, so an out-of-range ADDR_W selects nothing. Register 0 gets a
    // permanently inactive select when hard-wired to zero, so it stays at
    // its reset value of 0.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_word
            if (ZERO_REG0 && (i == 0)) begin : g_zero
                assign wr_sel[i] = 1'b0;
            end else begin : g_live
                assign wr_sel[i] = WRITE && (ADDR_W == AW'(i));
            end

            reg_word_param #(
                .WIDTH (WIDTH)
            ) u_word (
                .CLK   (CLK),
                .RESET (RESET),
                .LOAD  (wr_sel[i]),
                .D     (DATA_W),
                .Q     (mem_q[i])
            );
        end
    endgenerate

    // A write is accepted exactly when some word is selected. Out-of-range
    // and zero-register writes therefore never bypass.
    assign wr_accept = |wr_sel;

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]    rd_addr;
            logic [WIDTH-1:0] rd_d;

            assign rd_addr = ADDR_R[slice_lsb(k, AW) +: AW];

            // The default of 0 covers out-of-range addresses. Register 0
            // reads as 0 when hard-wired, because its word is never loaded
            // and the bypass cannot match it.
            always_comb begin
                rd_d = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (rd_addr == AW'(j)) begin
                        rd_d = mem_q[j];
                    end
                end
                if (wr_accept && (rd_addr == ADDR_W)) begin
                    rd_d = DATA_W;
                end
            end

            assign data_r_d[slice_lsb(k, WIDTH) +: WIDTH] = rd_d;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_r_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= READ;
            if (READ) begin
                data_r_q <= data_r_d;
            end
        end
    end

    assign DATA_R   = data_r_q;
    assign RD_VALID = rd_valid_q;

endmodule : reg_file_param
`default_nettype wire
